instr_encoder_writer: RTL and testbench
=======================================

INSTR_ENCODER_WRITER -- requirements
Module: instr_encoder_writer

Interface
REQ-001 SHALL have parameter DEPTH, default 64: instruction-memory capacity in words (power of two, 2..1024).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  request carries a valid instruction description.
REQ-006 SHALL have port in_ready  output  1  block accepts a request this cycle.
REQ-007 SHALL have port kind  input  4  instruction class: LOAD=0, STORE=1, RTYPE=2, MUL=3, ITYPE=4, BRANCH=5, LUI=6, AUIPC=7, JAL=8, JALR=9; 10-15 illegal.
REQ-008 SHALL have ports rd, rs1, rs2  input  5 each  register indices.
REQ-009 SHALL have port funct3  input  3  funct3 field.
REQ-010 SHALL have port alt  input  1  funct7[5] select (sub/sra/srai).
REQ-011 SHALL have port imm  input  32  immediate, byte offset for BRANCH/JAL, upper value in imm[31:12] for LUI/AUIPC.
REQ-012 SHALL have ports imem_we  output  1, imem_addr  output  32, imem_wdata  output  32: instruction-memory write port.
REQ-013 SHALL have ports clear  input  1  restart at word 0; count  output  $clog2(DEPTH)+1  words written; full  output  1; err  output  1  sticky illegal-request flag.

Function
REQ-014 SHALL accept a request when in_valid && in_ready; in_ready = 1 only in state IDLE.
REQ-015 SHALL use states IDLE, WRITE, FULL; IDLE->WRITE on accepted legal request; WRITE->IDLE after one cycle, or WRITE->FULL if count reaches DEPTH; FULL->IDLE only on clear.
REQ-016 SHALL register the encoded word on acceptance and assert imem_we for exactly the one WRITE cycle, i.e. one cycle after acceptance; throughput one instruction per two cycles.
REQ-017 SHALL drive imem_addr = BASE_ADDR + 4*index during WRITE and increment index and count at the end of WRITE.
REQ-018 SHALL encode opcodes: LOAD 0000011, STORE 0100011, RTYPE/MUL 0110011, ITYPE 0010011, BRANCH 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111.
REQ-019 SHALL place immediates: I [31:20]=imm[11:0]; S [31:25]=imm[11:5], [11:7]=imm[4:0]; B [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]; U [31:12]=imm[31:12]; J [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
REQ-020 SHALL set funct7: RTYPE {0,alt,00000}; MUL 0000001; ITYPE with funct3 001/101 [31:25]={0,alt,00000}, [24:20]=imm[4:0]; JALR funct3 forced 000.
REQ-021 SHALL treat illegal kind, or BRANCH/JAL with imm[0]=1, as illegal: accept it (in_ready handshake completes), set err, stay IDLE, no write.
REQ-022 SHALL, on clear in any state, return to IDLE, zero index and count, leave err unchanged; clear has priority over a simultaneous request (request not accepted).
REQ-023 SHALL drive imem_addr and imem_wdata to zero whenever imem_we = 0.
REQ-024 SHALL assert full = 1 iff count == DEPTH.

Reset
REQ-025 SHALL, on reset, enter IDLE with index=0, count=0, err=0, imem_we=0, full=0, imem_wdata=0; reset mid-WRITE aborts the write (no imem_we that cycle).
REQ-026 SHALL give reset priority over clear and in_valid.

Structure
REQ-027 SHALL place the kind encoding, opcode constants and imm-format enum in shared package riscv_pkg, so the decoder and this block use identical constants.
REQ-028 SHALL implement field packing as one combinational sub-module instr_pack (kind, fields -> 32-bit word, illegal flag); FSM, counters and registers live in instr_encoder_writer.

Verification
REQ-029 SHALL check ITYPE rd=1 rs1=0 funct3=000 imm=5 -> imem_we one cycle later, imem_addr=0x0, imem_wdata=0x00500093.
REQ-030 SHALL check RTYPE rd=3 rs1=1 rs2=2 -> 0x002081B3; MUL same fields -> 0x022081B3; LUI rd=5 imm=0x12345000 -> 0x123452B7.
REQ-031 SHALL check LOAD rd=5 rs1=2 funct3=010 imm=8 -> 0x00812283; STORE rs2=5 rs1=2 funct3=010 imm=12 -> 0x00512623.
REQ-032 SHALL check BRANCH rs1=1 rs2=2 funct3=000 imm=8 -> 0x00208463; JAL rd=1 imm=16 -> 0x010000EF; JAL imm=3 -> err=1, no write.
REQ-033 SHALL check DEPTH=4: four requests -> addresses 0x0,0x4,0x8,0xC, full=1, in_ready=0 on fifth; clear -> count=0, next write at 0x0.
REQ-034 SHALL check reset asserted in the WRITE cycle -> imem_we=0, count=0, state IDLE next cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// ============================================================================
// Module : riscv_pkg
// Shared RV32 encoding constants: instruction kinds, opcodes, immediate formats.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam logic [3:0] KIND_LOAD   = 4'd0;
  localparam logic [3:0] KIND_STORE  = 4'd1;
  localparam logic [3:0] KIND_RTYPE  = 4'd2;
  localparam logic [3:0] KIND_MUL    = 4'd3;
  localparam logic [3:0] KIND_ITYPE  = 4'd4;
  localparam logic [3:0] KIND_BRANCH = 4'd5;
  localparam logic [3:0] KIND_LUI    = 4'd6;
  localparam logic [3:0] KIND_AUIPC  = 4'd7;
  localparam logic [3:0] KIND_JAL    = 4'd8;
  localparam logic [3:0] KIND_JALR   = 4'd9;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // FMT_SH is the I-type shift form: funct7 in [31:25], shamt in [24:20]
  typedef enum logic [2:0] {
    FMT_R  = 3'd0,
    FMT_I  = 3'd1,
    FMT_SH = 3'd2,
    FMT_S  = 3'd3,
    FMT_B  = 3'd4,
    FMT_U  = 3'd5,
    FMT_J  = 3'd6
  } imm_fmt_e;

endpackage

`default_nettype wire

// File: rtl/instr_pack.sv
// ============================================================================
// Module : instr_pack
// Combinational packer: instruction description -> 32-bit RV32 word + illegal.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module instr_pack
  import riscv_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic        alt,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] f3;
  imm_fmt_e   fmt;

  always_comb begin
    opcode  = 7'd0;
    funct7  = 7'd0;
    f3      = funct3;
    fmt     = FMT_R;
    illegal = 1'b0;
    case (kind)
      KIND_LOAD:   begin opcode = OPC_LOAD;   fmt = FMT_I; end
      KIND_STORE:  begin opcode = OPC_STORE;  fmt = FMT_S; end
      KIND_RTYPE:  begin opcode = OPC_OP;     fmt = FMT_R; funct7 = {1'b0, alt, 5'b00000}; end
      KIND_MUL:    begin opcode = OPC_OP;     fmt = FMT_R; funct7 = 7'b0000001; end
      KIND_ITYPE: begin
        opcode = OPC_OP_IMM;
        funct7 = {1'b0, alt, 5'b00000};
        fmt    = (funct3 == 3'b001 || funct3 == 3'b101) ? FMT_SH : FMT_I;
      end
      // control-flow targets must be halfword aligned
      KIND_BRANCH: begin opcode = OPC_BRANCH; fmt = FMT_B; illegal = imm[0]; end
      KIND_LUI:    begin opcode = OPC_LUI;    fmt = FMT_U; end
      KIND_AUIPC:  begin opcode = OPC_AUIPC;  fmt = FMT_U; end
      KIND_JAL:    begin opcode = OPC_JAL;    fmt = FMT_J; illegal = imm[0]; end
      KIND_JALR:   begin opcode = OPC_JALR;   fmt = FMT_I; f3 = 3'b000; end
      default:     illegal = 1'b1;
    endcase

    case (fmt)
      FMT_R:   word = {funct7, rs2, rs1, f3, rd, opcode};
      FMT_I:   word = {imm[11:0], rs1, f3, rd, opcode};
      FMT_SH:  word = {funct7, imm[4:0], rs1, f3, rd, opcode};
      FMT_S:   word = {imm[11:5], rs2, rs1, f3, imm[4:0], opcode};
      FMT_B:   word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opcode};
      FMT_U:   word = {imm[31:12], rd, opcode};
      FMT_J:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: word = 32'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/instr_encoder_writer.sv
// ============================================================================
// Module : instr_encoder_writer
// Encodes instruction requests and writes them sequentially into an imem.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module instr_encoder_writer
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               kind,
  input  logic [4:0]               rd,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  input  logic [2:0]               funct3,
  input  logic                     alt,
  input  logic [31:0]              imm,
  output logic                     imem_we,
  output logic [31:0]              imem_addr,
  output logic [31:0]              imem_wdata,
  input  logic                     clear,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     err
);

  localparam int unsigned  AW      = $clog2(DEPTH);
  localparam int unsigned  CW      = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;

  logic [31:0]   pack_word;
  logic          pack_illegal;
  logic          accept;
  logic [CW-1:0] count_inc;

  instr_pack u_pack (
    .kind    (kind),
    .rd      (rd),
    .rs1     (rs1),
    .rs2     (rs2),
    .funct3  (funct3),
    .alt     (alt),
    .imm     (imm),
    .word    (pack_word),
    .illegal (pack_illegal)
  );

  // clear wins over a simultaneous request, so it also withholds ready
  assign in_ready  = (state_q == ST_IDLE) && !clear;
  assign accept    = in_valid && in_ready;
  assign count_inc = count_q + CW'(1);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = 32'd0;
    wdata_d = 32'd0;
    if (clear) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (pack_illegal) begin
              err_d = 1'b1;
            end else begin
              state_d = ST_WRITE;
              we_d    = 1'b1;
              addr_d  = BASE_ADDR + {{(30-AW){1'b0}}, count_q[AW-1:0], 2'b00};
              wdata_d = pack_word;
            end
          end
        end
        ST_WRITE: begin
          count_d = count_inc;
          state_d = (count_inc == DEPTH_C) ? ST_FULL : ST_IDLE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // reset landing in the WRITE cycle suppresses the pending write immediately
  assign imem_we    = we_q && !reset;
  assign imem_addr  = imem_we ? addr_q  : 32'd0;
  assign imem_wdata = imem_we ? wdata_q : 32'd0;
  assign count      = count_q;
  assign full       = (count_q == DEPTH_C);
  assign err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder_writer.sv
// ============================================================================
// Module : tb_instr_encoder_writer
// Directed scoreboard bench for instr_encoder_writer (DEPTH=4).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_instr_encoder_writer;
  import riscv_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  kind;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        alt;
  logic [31:0] imm;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        clear;
  logic [2:0]  count;
  logic        full;
  logic        err;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         sb[$];
  wr_t         exp_wr;
  int          checks;
  int          failures;
  int          exp_idx;
  logic        mon_en;

  instr_encoder_writer #(.DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .kind       (kind),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .funct3     (funct3),
    .alt        (alt),
    .imm        (imm),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .clear      (clear),
    .count      (count),
    .full       (full),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (imem_we) begin
        chk("write_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_wr = sb.pop_front();
          chk("imem_addr", imem_addr, exp_wr.addr);
          chk("imem_wdata", imem_wdata, exp_wr.data);
        end
      end else begin
        chk("idle_addr", imem_addr, 32'd0);
        chk("idle_wdata", imem_wdata, 32'd0);
      end
    end
  end

  task automatic drive(input logic [3:0] k, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [2:0] f3, input logic a,
                       input logic [31:0] im);
    kind = k; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; alt = a; imm = im;
    in_valid = 1'b1;
  endtask

  // one request; returns at the negedge inside the (possible) WRITE cycle
  task automatic send(input logic [3:0] k, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [2:0] f3, input logic a,
                      input logic [31:0] im, input logic [31:0] exp_word, input bit legal);
    @(negedge clk);
    drive(k, d, s1, s2, f3, a, im);
    chk("in_ready", 32'(in_ready), 32'd1);
    if (legal) begin
      sb.push_back('{addr: 32'(exp_idx * 4), data: exp_word});
      exp_idx++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("we_latency", 32'(imem_we), 32'(legal));
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    exp_idx = 0;
  endtask

  initial begin
    checks = 0; failures = 0; exp_idx = 0; mon_en = 1'b0;
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0;
    kind = 4'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; funct3 = 3'd0; alt = 1'b0; imm = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;

    @(negedge clk);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);

    send(KIND_ITYPE, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5, 32'h0050_0093, 1'b1);
    send(KIND_RTYPE, 5'd3, 5'd1, 5'd2, 3'b000, 1'b0, 32'd0, 32'h0020_81B3, 1'b1);
    send(KIND_MUL,   5'd3, 5'd1, 5'd2, 3'b000, 1'b0, 32'd0, 32'h0220_81B3, 1'b1);
    send(KIND_LUI,   5'd5, 5'd0, 5'd0, 3'b000, 1'b0, 32'h1234_5000, 32'h1234_52B7, 1'b1);

    @(negedge clk);
    chk("full_flag", 32'(full), 32'd1);
    chk("full_count", 32'(count), 32'd4);
    drive(KIND_ITYPE, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5);
    chk("full_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("full_hold", 32'(count), 32'd4);

    do_clear();
    @(negedge clk);
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_full", 32'(full), 32'd0);
    chk("clr_ready", 32'(in_ready), 32'd1);

    send(KIND_LOAD,   5'd5, 5'd2, 5'd0, 3'b010, 1'b0, 32'd8,  32'h0081_2283, 1'b1);
    send(KIND_STORE,  5'd0, 5'd2, 5'd5, 3'b010, 1'b0, 32'd12, 32'h0051_2623, 1'b1);
    send(KIND_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'd8,  32'h0020_8463, 1'b1);
    send(KIND_JAL,    5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd16, 32'h0100_00EF, 1'b1);

    do_clear();
    send(KIND_JAL, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd3, 32'd0, 1'b0);
    chk("jal_odd_err", 32'(err), 32'd1);
    chk("jal_odd_count", 32'(count), 32'd0);

    // clear and request together: clear wins, nothing is written
    @(negedge clk);
    clear = 1'b1;
    drive(KIND_ITYPE, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5);
    @(posedge clk);
    #1 begin clear = 1'b0; in_valid = 1'b0; end
    @(negedge clk);
    chk("clr_prio_we", 32'(imem_we), 32'd0);
    chk("clr_prio_count", 32'(count), 32'd0);
    chk("clr_keeps_err", 32'(err), 32'd1);

    // reset during the WRITE cycle
    @(negedge clk);
    drive(KIND_ITYPE, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5);
    @(posedge clk);
    #1 begin in_valid = 1'b0; reset = 1'b1; end
    @(negedge clk);
    chk("rst_write_we", 32'(imem_we), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    exp_idx = 0;
    @(negedge clk);
    chk("rst_write_count", 32'(count), 32'd0);
    chk("rst_write_ready", 32'(in_ready), 32'd1);
    chk("rst_write_err", 32'(err), 32'd0);

    send(4'd12, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd0, 32'd0, 1'b0);
    chk("bad_kind_err", 32'(err), 32'd1);

    send(KIND_ITYPE, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5, 32'h0050_0093, 1'b1);
    @(negedge clk);
    chk("final_count", 32'(count), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
